led_bank_arbiter: RTL

- Controller that shares the board's LED output bank between NUM_REQ requesters.
- Round-robin arbitration with a minimum hold time measured in prescaler ticks; break-before-make handover.
- When no requester owns the bank, it shows a free-running idle counter that advances once per prescaler tick.
- Sits between user logic and the LED output buffers; its leds output drives the output IOBs directly.

---
 rtl/led_arb_pkg.sv | 42 ++++
 rtl/led_tick_gen.sv | 25 ++
 rtl/led_bank_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_arb_pkg.sv
// Shared constants, FSM state encoding and the round-robin pick for the LED bank arbiter.
// Pure combinational helpers; no latency or backpressure of their own.
package led_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_LED_W      = 8;
  localparam int DEF_PRESCALE_W = 18;
  localparam int DEF_HOLD_TICKS = 4;

  // Widest requester vector the pick function supports; callers zero-extend.
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rr_pick_t;

  // Lowest requester above ptr wins; if none, wrap to the lowest requester overall.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr);
    rr_pick_t           pick;
    logic [MAX_REQ-1:0] above;
    pick = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      above[i] = req[i] && (i > int'(ptr));
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick.vld = 1'b1;
        pick.idx = 3'(i);
      end
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (above[i]) pick.idx = 3'(i);
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every 2^PRESCALE_W clk cycles, registered.
// Tick follows the all-ones count by one cycle; never stalls, no backpressure.
module led_tick_gen
  import led_arb_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + PRESCALE_W'(1);
      tick <= &cnt;
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the LED bank with min hold time and break-before-make; LED_ACTIVE_LOW_EN inverts leds.
// req->grant 1 cycle, grant->leds 1 cycle; requesters are never stalled, they just wait for a grant.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int LED_W      = DEF_LED_W,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         leds,
  output logic                     busy,
  output logic                     tick
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_POL = '1;
`else
  localparam logic [LED_W-1:0] LED_POL = '0;
`endif

  logic [1:0]         state;
  logic [2:0]         rr_ptr;
  logic [7:0]         hold_cnt;
  logic [LED_W-1:0]   idle_ctr;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;
  logic [NUM_REQ-1:0] pick_grant;
  logic [LED_W-1:0]   owner_pat;
  logic               owner_req;
  logic               rival_req;

  led_tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // grant is one-hot while owning, so it doubles as the owner select.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    pick                 = rr_pick(req_ext, rr_ptr);
    pick_grant           = '0;
    owner_pat            = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_grant[i] = pick.vld && (pick.idx == 3'(i));
      owner_pat     = owner_pat | (pattern[i*LED_W +: LED_W] & {LED_W{grant[i]}});
    end
    owner_req = |(req & grant);
    rival_req = |(req & ~grant);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= 3'(NUM_REQ - 1);
      hold_cnt <= '0;
      idle_ctr <= '0;
      leds     <= LED_POL;
    end else begin
      if (tick) idle_ctr <= idle_ctr + LED_W'(1);
      case (state)
        ST_IDLE: begin
          leds <= idle_ctr ^ LED_POL;
          if (pick.vld) begin
            grant    <= pick_grant;
            rr_ptr   <= pick.idx;
            hold_cnt <= 8'(HOLD_TICKS);
            state    <= ST_OWN;
          end
        end
        ST_OWN: begin
          leds <= owner_pat ^ LED_POL;
          if (tick && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
          if (!owner_req || (hold_cnt == 8'd0 && rival_req)) begin
            grant <= '0;
            state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          // leds deliberately not written: the bank holds its last image across the gap.
          if (pick.vld) begin
            grant    <= pick_grant;
            rr_ptr   <= pick.idx;
            hold_cnt <= 8'(HOLD_TICKS);
            state    <= ST_OWN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
